// File: rtl/rvfi_pkg.sv
// rtl/rvfi_pkg.sv - shared RVFI commit record type and opcode constants
// Provides rvfi_word_t (one retired-instruction record) and OPC_STORE,
// imported by the commit queue, its interface and the per-slot fixup.
package rvfi_pkg;

    localparam logic [6:0] OPC_STORE = 7'b0100011;

    typedef struct packed {
        logic [31:0] pc_rdata;
        logic [31:0] pc_wdata;
        logic [31:0] inst;
        logic [4:0]  rs1_addr;
        logic [4:0]  rs2_addr;
        logic [31:0] rs1_rdata;
        logic [31:0] rs2_rdata;
        logic [4:0]  rd_addr;
        logic [31:0] rd_wdata;
        logic        load_regfile;
        logic [31:0] mem_addr;
        logic [3:0]  mem_rmask;
        logic [3:0]  mem_wmask;
        logic [31:0] mem_rdata;
        logic [31:0] mem_wdata;
    } rvfi_word_t;

endpackage

// File: rtl/rvfi_commit_queue_if.sv
// rtl/rvfi_commit_queue_if.sv - commit-in / record-out handshake bundle
// Producer side: in_valid[NRET], in_word[NRET], redirect, redirect_pc -> in_ready.
// Consumer side: out_valid, out_word, out_order -> out_ready.
// slave: the queue's view; master: the ROB/consumer (bench) view.
interface rvfi_commit_queue_if #(
    parameter int NRET = 2
);
    import rvfi_pkg::*;

    logic [NRET-1:0]        in_valid;
    rvfi_word_t [NRET-1:0]  in_word;
    logic                   redirect;
    logic [31:0]            redirect_pc;
    logic                   in_ready;
    logic                   out_valid;
    rvfi_word_t             out_word;
    logic [63:0]            out_order;
    logic                   out_ready;

    modport slave (
        input  in_valid, in_word, redirect, redirect_pc, out_ready,
        output in_ready, out_valid, out_word, out_order
    );

    modport master (
        output in_valid, in_word, redirect, redirect_pc, out_ready,
        input  in_ready, out_valid, out_word, out_order
    );

endinterface

// File: rtl/rvfi_word_fixup.sv
// rtl/rvfi_word_fixup.sv - per-slot commit record normalisation
// Ports: word_in (raw record), apply_redirect (this slot is the redirected
// youngest slot), redirect_pc (corrected next PC), word_out (normalised record).
module rvfi_word_fixup
    import rvfi_pkg::*;
(
    input  rvfi_word_t  word_in,
    input  logic        apply_redirect,
    input  logic [31:0] redirect_pc,
    output rvfi_word_t  word_out
);

    always_comb begin
        word_out = word_in;
        if (apply_redirect) begin
            word_out.pc_wdata = redirect_pc;
        end
        // Stores never write the register file.
        if (word_in.inst[6:0] == OPC_STORE) begin
            word_out.rd_addr      = 5'd0;
            word_out.load_regfile = 1'b0;
        end
        // x0 writes are reported as zero; evaluated after the store override.
        if (word_out.rd_addr == 5'd0) begin
            word_out.rd_wdata = 32'd0;
        end
    end

endmodule

// File: rtl/rvfi_commit_queue.sv
// rtl/rvfi_commit_queue.sv - multi-slot RVFI retirement queue with order tagging
// Ports: clk, rst (async active-low), bus (rvfi_commit_queue_if.slave: commit
// slots in, head record out), flush (sync clear), halt (sticky self-loop seen),
// proto_err (sticky protocol violation), count (occupied entries).
module rvfi_commit_queue
    import rvfi_pkg::*;
#(
    parameter int NRET  = 2,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    rvfi_commit_queue_if.slave         bus,
    input  logic                       flush,
    output logic                       halt,
    output logic                       proto_err,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] READY_MAX = CW'(DEPTH - NRET);

    rvfi_word_t      mem     [DEPTH];
    logic [63:0]     ord_mem [DEPTH];
    rvfi_word_t      fixed   [NRET];

    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [63:0]     order_ctr;

    logic [NRET:0]   valid_ext;
    logic [NRET-1:0] youngest;
    logic            gap;
    logic            any_valid;
    logic            in_ready_int;
    logic            out_valid_int;
    logic            enq;
    logic            deq;
    logic            err;
    logic            halt_set;
    logic [CW-1:0]   pop;
    logic [CW-1:0]   enq_cnt;

    // Ready depends only on registered state so out_ready never reaches it.
    assign in_ready_int  = !halt && (count <= READY_MAX);
    assign out_valid_int = (count != '0) && !halt;

    always_comb begin
        valid_ext = {1'b0, bus.in_valid};
        youngest  = '0;
        gap       = 1'b0;
        pop       = '0;
        for (int i = 0; i < NRET; i++) begin
            youngest[i] = valid_ext[i] & ~valid_ext[i+1];
            gap         = gap | (valid_ext[i+1] & ~valid_ext[i]);
            pop         = pop + CW'(valid_ext[i]);
        end
        any_valid = |bus.in_valid;
        err       = any_valid && (gap || !in_ready_int);
        enq       = any_valid && !err;
        enq_cnt   = enq ? pop : '0;
        deq       = out_valid_int && bus.out_ready;
        halt_set  = deq && (mem[rd_ptr].pc_rdata == mem[rd_ptr].pc_wdata);
    end

    for (genvar g = 0; g < NRET; g++) begin : g_fixup
        rvfi_word_fixup u_fixup (
            .word_in        (bus.in_word[g]),
            .apply_redirect (bus.redirect & youngest[g]),
            .redirect_pc    (bus.redirect_pc),
            .word_out       (fixed[g])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count     <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            order_ctr <= '0;
            halt      <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            // Order numbers are consumed by every accepted commit, even one
            // that a same-cycle flush or halt throws away.
            order_ctr <= order_ctr + 64'(enq_cnt);
            if (err) begin
                proto_err <= 1'b1;
            end
            if (halt_set) begin
                halt <= 1'b1;
            end
            if (flush || halt_set) begin
                count  <= '0;
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                count  <= count + enq_cnt - CW'(deq);
                wr_ptr <= wr_ptr + PW'(enq_cnt);
                if (deq) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
            end
        end
    end

    // Payload storage carries no reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (enq) begin
            for (int i = 0; i < NRET; i++) begin
                if (bus.in_valid[i]) begin
                    mem[wr_ptr + PW'(i)]     <= fixed[i];
                    ord_mem[wr_ptr + PW'(i)] <= order_ctr + 64'(i);
                end
            end
        end
    end

    assign bus.in_ready  = in_ready_int;
    assign bus.out_valid = out_valid_int;
    assign bus.out_word  = mem[rd_ptr];
    assign bus.out_order = ord_mem[rd_ptr];

endmodule

// File: doc/rvfi_commit_queue.md
RVFI_COMMIT_QUEUE -- requirements
Module: rvfi_commit_queue

Interface
REQ-001 SHALL have parameter NRET, default 2, max commits accepted per cycle (1..4).
REQ-002 SHALL have parameter DEPTH, default 8, queue entries (power of two, >= 2*NRET).
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on posedge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  in  NRET  per-slot commit valid from ROB; slot 0 oldest.
REQ-006 SHALL have port in_word  in  NRET x rvfi_word_t  per-slot commit record.
REQ-007 SHALL have port redirect  in  1  mispredict on youngest valid slot this cycle.
REQ-008 SHALL have port redirect_pc  in  32  corrected next PC for that slot.
REQ-009 SHALL have port flush  in  1  synchronous clear of queued entries.
REQ-010 SHALL have port in_ready  out  1  high when free entries >= NRET and not halted.
REQ-011 SHALL have port out_valid  out  1  head entry valid.
REQ-012 SHALL have port out_word  out  rvfi_word_t  head entry record.
REQ-013 SHALL have port out_order  out  64  retirement order of head entry.
REQ-014 SHALL have port out_ready  in  1  consumer accepts head.
REQ-015 SHALL have port halt  out  1  sticky; program reached self-loop.
REQ-016 SHALL have port proto_err  out  1  sticky protocol violation flag.
REQ-017 SHALL have port count  out  $clog2(DEPTH+1)  occupied entries.

Function
REQ-018 Enqueue SHALL occur when in_ready & |in_valid; k = popcount(in_valid) entries written at wr_ptr..wr_ptr+k-1 modulo DEPTH, slot order preserved.
REQ-019 Each enqueued entry SHALL be tagged order = order_ctr + slot index; order_ctr SHALL advance by k; order_ctr unaffected by flush.
REQ-020 When redirect is high, the youngest valid slot's pc_wdata SHALL be replaced by redirect_pc before storage.
REQ-021 Slot normalisation before storage: store opcode (7'b0100011) forces rd_addr=0 and load_regfile=0; rd_addr==0 forces rd_wdata=0.
REQ-022 Dequeue SHALL occur when out_valid & out_ready; rd_ptr advances by 1, wrapping modulo DEPTH.
REQ-023 out_word/out_order SHALL be driven from head entry (show-ahead); enqueue-to-out_valid latency exactly 1 cycle.
REQ-024 Simultaneous enqueue and dequeue SHALL be allowed; count_next = count + k - deq.
REQ-025 in_ready SHALL be computed from registered count only (no combinational path from out_ready).
REQ-026 in_valid non-contiguous (valid[i] & !valid[i-1]), or any in_valid while in_ready low, SHALL set proto_err and drop the whole cycle's input without advancing order_ctr.
REQ-027 Dequeue of an entry with pc_rdata == pc_wdata SHALL set halt on the next edge; that entry is still delivered.
REQ-028 After halt: in_ready held 0, remaining queued entries discarded on the cycle halt sets, out_valid 0 thereafter until reset.
REQ-029 flush SHALL empty queue next cycle (pointers, count to 0); flush has priority over same-cycle enqueue and dequeue.
REQ-030 Full (count==DEPTH) SHALL deassert in_ready; empty (count==0) SHALL deassert out_valid.

Reset
REQ-031 On rst low (async): count, rd_ptr, wr_ptr, order_ctr = 0; out_valid, in_ready-enabling state, halt, proto_err = 0; entry storage need not clear.
REQ-032 Reset asserted mid-transfer SHALL abandon all queued entries; first commit after release gets order 0.
REQ-033 in_ready SHALL be 1 in the first cycle after reset release.

Structure
REQ-034 rvfi_word_t (pc_rdata, pc_wdata, inst, rs1/rs2 addr+rdata, rd_addr, rd_wdata, load_regfile, mem fields) and OPC_STORE SHALL live in shared package rvfi_pkg.
REQ-035 Per-slot normalisation (REQ-020/021) SHALL be sub-module rvfi_word_fixup, instantiated NRET times.
REQ-036 Storage SHALL be a flop array indexed by pointers; no memory macro.

Verification
REQ-037 NRET=2: commit valid=2'b11 pcs 0x60/0x64 -> out in order 0,1 on consecutive accepting cycles, count peaks 2.
REQ-038 Fill to DEPTH=8 with out_ready=0 -> in_ready low at count 7; valid pushed anyway -> proto_err=1, count stays 7.
REQ-039 redirect=1, slot1 pc_wdata=0x80, redirect_pc=0x200 -> dequeued slot1 pc_wdata=0x200.
REQ-040 Store inst 0x00112023 with rd_addr=5 -> out rd_addr=0, load_regfile=0; rd_addr=0 rd_wdata=0xDEAD -> out rd_wdata=0.
REQ-041 Entry pc_rdata=pc_wdata=0x1C8 dequeued with 3 behind it -> halt=1 next cycle, out_valid=0, in_ready=0 until reset.
REQ-042 rst low with count=5, order_ctr=12 -> all outputs zero immediately; next commit out_order=0.
